// File: rtl/jtag_1149_d10_mstr_rx_link_ctrl_pkg.sv
// Shared definitions for the IEEE 1149.10 master receive-link controller:
// special characters, state encodings and counter widths.
package jtag_1149_d10_mstr_rx_link_ctrl_pkg;

    localparam logic [7:0] IDLE_CHAR  = 8'hBC;
    localparam logic [7:0] ERROR_CHAR = 8'hFE;

    localparam int CNT_W = 4;
    localparam int TMR_W = 8;

    typedef enum logic [2:0] {
        ST_DISABLED = 3'd0,
        ST_HUNT     = 3'd1,
        ST_LOCKED   = 3'd2,
        ST_ERR_HOLD = 3'd3,
        ST_RESYNC   = 3'd4
    } link_state_e;

endpackage

// File: rtl/jtag_1149_d10_mstr_rx_link_ctrl_if.sv
// Symbol/status bundle between the decoder side (master) and the rx link
// controller (slave).
interface jtag_1149_d10_mstr_rx_link_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    // sym_valid qualifies decoded_data/decoder_k_out/code_err for exactly the
    // cycle it is high; there is no ready, so the controller must accept every
    // valid symbol. rx_data_valid likewise marks a one-cycle payload beat.
    logic                  link_en;
    logic                  sym_valid;
    logic [DATA_WIDTH-1:0] decoded_data;
    logic                  decoder_k_out;
    logic                  code_err;
    logic                  error_char_detected;
    logic                  link_up;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_data_valid;
    logic                  remote_err;
    logic                  resync_req;
    logic [2:0]            link_state;
    logic [15:0]           err_cnt;

    modport master (
        output link_en, sym_valid, decoded_data, decoder_k_out, code_err,
               error_char_detected,
        input  link_up, rx_data, rx_data_valid, remote_err, resync_req,
               link_state, err_cnt
    );

    modport slave (
        input  link_en, sym_valid, decoded_data, decoder_k_out, code_err,
               error_char_detected,
        output link_up, rx_data, rx_data_valid, remote_err, resync_req,
               link_state, err_cnt
    );
endinterface

// File: rtl/jtag_1149_d10_mstr_rx_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module jtag_1149_d10_mstr_rx_sat_cnt #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/jtag_1149_d10_mstr_rx_link_ctrl.sv
// IEEE 1149.10 master rx link controller: IDLE hunt/lock, payload forwarding,
// far-end error hold and timed resync. Optional macro JTAG_1149_D10_RX_ERR_CNT_EN.
module jtag_1149_d10_mstr_rx_link_ctrl
    import jtag_1149_d10_mstr_rx_link_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int LOCK_IDLE_CNT = 4,
    parameter int MAX_CODE_ERR  = 3,
    parameter int RESYNC_WAIT   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    jtag_1149_d10_mstr_rx_link_ctrl_if.slave   bus
);
    link_state_e           state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic                  link_up_q, link_up_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_data_valid_q, rx_data_valid_d;
    logic                  remote_err_q, remote_err_d;
    logic                  resync_req_q, resync_req_d;

    logic [CNT_W-1:0]      idle_cnt;
    logic [CNT_W-1:0]      cerr_cnt;
    logic                  is_idle, in_lock, fwd;
    logic                  idle_inc, idle_hit, idle_clr;
    logic                  cerr_inc, cerr_hit, cerr_clr;

    // A code error disqualifies an IDLE both for lock acquisition and for leaving ERR_HOLD.
    assign is_idle  = (bus.decoded_data == DATA_WIDTH'(IDLE_CHAR)) && bus.decoder_k_out
                      && !bus.code_err;
    assign in_lock  = (state_q == ST_LOCKED) || (state_q == ST_ERR_HOLD);

    assign idle_inc = (state_q == ST_HUNT) && bus.sym_valid && is_idle;
    assign idle_hit = idle_inc && (idle_cnt == CNT_W'(LOCK_IDLE_CNT - 1));
    assign idle_clr = !bus.link_en || (state_q != ST_HUNT) || (bus.sym_valid && !is_idle)
                      || idle_hit;

    assign cerr_inc = in_lock && bus.sym_valid && bus.code_err;
    assign cerr_hit = cerr_inc && (cerr_cnt == CNT_W'(MAX_CODE_ERR - 1));
    assign cerr_clr = !bus.link_en || !in_lock || (bus.sym_valid && !bus.code_err)
                      || cerr_hit;

    jtag_1149_d10_mstr_rx_sat_cnt #(.W(CNT_W)) u_idle_cnt (
        .clk (clk), .rst (rst), .clr (idle_clr), .inc (idle_inc), .cnt (idle_cnt)
    );

    jtag_1149_d10_mstr_rx_sat_cnt #(.W(CNT_W)) u_cerr_cnt (
        .clk (clk), .rst (rst), .clr (cerr_clr), .inc (cerr_inc), .cnt (cerr_cnt)
    );

`ifdef JTAG_1149_D10_RX_ERR_CNT_EN
    logic err_inc;
    assign err_inc = bus.sym_valid && bus.code_err && (state_q != ST_DISABLED);

    jtag_1149_d10_mstr_rx_sat_cnt #(.W(16), .MAX(16'hFFFF)) u_err_cnt (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (err_inc), .cnt (bus.err_cnt)
    );
`else
    assign bus.err_cnt = 16'h0000;
`endif

    always_comb begin
        state_d = state_q;
        fwd     = 1'b0;
        if (!bus.link_en) begin
            state_d = ST_DISABLED;
        end else begin
            case (state_q)
                ST_DISABLED: state_d = ST_HUNT;
                ST_HUNT: begin
                    if (idle_hit) state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (bus.sym_valid) begin
                        if (bus.code_err) begin
                            if (cerr_hit) state_d = ST_RESYNC;
                        end else if (bus.error_char_detected) begin
                            state_d = ST_ERR_HOLD;
                        end else if (!bus.decoder_k_out) begin
                            fwd = 1'b1;
                        end
                    end
                end
                ST_ERR_HOLD: begin
                    if (bus.sym_valid) begin
                        if (cerr_hit)     state_d = ST_RESYNC;
                        else if (is_idle) state_d = ST_LOCKED;
                    end
                end
                ST_RESYNC: begin
                    if (timer_q == '0) state_d = ST_HUNT;
                end
                default: state_d = ST_DISABLED;
            endcase
        end
    end

    // Timer runs on every cycle in RESYNC; sym_valid gaps do not stall it.
    always_comb begin
        timer_d = timer_q;
        if (!bus.link_en) begin
            timer_d = '0;
        end else if ((state_q != ST_RESYNC) && (state_d == ST_RESYNC)) begin
            timer_d = TMR_W'(RESYNC_WAIT - 1);
        end else if ((state_q == ST_RESYNC) && (timer_q != '0)) begin
            timer_d = timer_q - 1'b1;
        end
    end

    always_comb begin
        link_up_d       = (state_d == ST_LOCKED) || (state_d == ST_ERR_HOLD);
        rx_data_valid_d = fwd;
        rx_data_d       = fwd ? bus.decoded_data : rx_data_q;
        remote_err_d    = (state_q == ST_LOCKED) && (state_d == ST_ERR_HOLD);
        resync_req_d    = (state_d == ST_RESYNC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_DISABLED;
            timer_q         <= '0;
            link_up_q       <= 1'b0;
            rx_data_q       <= '0;
            rx_data_valid_q <= 1'b0;
            remote_err_q    <= 1'b0;
            resync_req_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            link_up_q       <= link_up_d;
            rx_data_q       <= rx_data_d;
            rx_data_valid_q <= rx_data_valid_d;
            remote_err_q    <= remote_err_d;
            resync_req_q    <= resync_req_d;
        end
    end

    assign bus.link_state    = state_q;
    assign bus.link_up       = link_up_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_data_valid = rx_data_valid_q;
    assign bus.remote_err    = remote_err_q;
    assign bus.resync_req    = resync_req_q;
endmodule

// File: tb/tb_jtag_1149_d10_mstr_rx_link_ctrl.sv
// Directed bench for the rx link controller with a payload scoreboard.
module tb_jtag_1149_d10_mstr_rx_link_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];

`ifdef JTAG_1149_D10_RX_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    jtag_1149_d10_mstr_rx_link_ctrl_if #(.DATA_WIDTH(8)) bus ();

    jtag_1149_d10_mstr_rx_link_ctrl #(
        .DATA_WIDTH(8), .LOCK_IDLE_CNT(4), .MAX_CODE_ERR(3), .RESYNC_WAIT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] errs(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    // driver: present one cycle of symbol inputs, then sample 1 time unit after the edge
    task automatic drive(input logic v, input logic [7:0] d, input logic k,
                         input logic ce, input logic ec);
        bus.sym_valid           = v;
        bus.decoded_data        = d;
        bus.decoder_k_out       = k;
        bus.code_err            = ce;
        bus.error_char_detected = ec;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_k();
        drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic gap();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [7:0] d);
        exp_q.push_back(d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic cerr();
        drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    // scoreboard: every forwarded byte must match the oldest expected byte
    always @(negedge clk) begin
        if (!rst && bus.rx_data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rx_unexpected observed=%0h expected=none", bus.rx_data);
            end else begin
                chk("rx_data_sb", {24'd0, bus.rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int n;
        bus.link_en = 1'b0;
        bus.sym_valid = 1'b0;
        bus.decoded_data = 8'h00;
        bus.decoder_k_out = 1'b0;
        bus.code_err = 1'b0;
        bus.error_char_detected = 1'b0;

        #3;
        chk("rst_state", bus.link_state, 0);
        chk("rst_link_up", bus.link_up, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_data_valid, 0);
        chk("rst_remote_err", bus.remote_err, 0);
        chk("rst_resync_req", bus.resync_req, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // lock acquisition with a broken run and sym_valid gaps
        bus.link_en = 1'b1;
        gap();
        chk("hunt_entry", bus.link_state, 1);
        repeat (3) idle_k();
        drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("hunt_after_break", bus.link_state, 1);
        repeat (2) idle_k();
        repeat (2) gap();
        idle_k();
        chk("hunt_three_idles", bus.link_state, 1);
        chk("hunt_link_up", bus.link_up, 0);
        idle_k();
        chk("lock_state", bus.link_state, 2);
        chk("lock_link_up", bus.link_up, 1);

        // forwarding
        send(8'h12);
        chk("fwd_valid_12", bus.rx_data_valid, 1);
        chk("fwd_data_12", bus.rx_data, 8'h12);
        send(8'h34);
        chk("fwd_data_34", bus.rx_data, 8'h34);
        idle_k();
        chk("k_not_fwd_valid", bus.rx_data_valid, 0);
        chk("k_hold_data", bus.rx_data, 8'h34);
        drive(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("k3c_not_fwd", bus.rx_data_valid, 0);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                gap();
                chk("gap_no_valid", bus.rx_data_valid, 0);
            end
            send(8'($urandom_range(0, 255)));
        end

        // far-end error
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        chk("fe_state", bus.link_state, 3);
        chk("fe_remote_err", bus.remote_err, 1);
        chk("fe_no_fwd", bus.rx_data_valid, 0);
        chk("fe_link_up", bus.link_up, 1);
        drive(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("hold_state", bus.link_state, 3);
        chk("hold_remote_err_pulse", bus.remote_err, 0);
        chk("hold_no_fwd", bus.rx_data_valid, 0);
        drive(1'b1, 8'hBC, 1'b1, 1'b0, 1'b1);
        chk("hold_exit_state", bus.link_state, 2);
        chk("hold_exit_remote_err", bus.remote_err, 0);

        // code errors: err, good, err, err stays locked; third in a row resyncs
        cerr();
        send(8'h20);
        cerr();
        cerr();
        chk("cerr_no_resync", bus.link_state, 2);
        cerr();
        chk("resync_state", bus.link_state, 4);
        chk("resync_link_up", bus.link_up, 0);
        chk("resync_req_on", bus.resync_req, 1);
        chk("err_cnt_4", bus.err_cnt, errs(4));
        n = 1;
        for (int i = 0; i < 40; i++) begin
            drive(i[0], 8'hBC, 1'b1, 1'b0, 1'b0);
            if (bus.resync_req) n++;
            else break;
        end
        chk("resync_len", 32'(n), 16);
        chk("resync_exit_state", bus.link_state, 1);

        // re-hunt starts from a zero idle count
        cerr();
        chk("err_cnt_5", bus.err_cnt, errs(5));
        repeat (3) idle_k();
        chk("rehunt_state", bus.link_state, 1);
        idle_k();
        chk("relock_state", bus.link_state, 2);

        // disable while locked
        bus.link_en = 1'b0;
        send(8'h55);
        void'(exp_q.pop_back());
        chk("dis_state", bus.link_state, 0);
        chk("dis_link_up", bus.link_up, 0);
        chk("dis_no_fwd", bus.rx_data_valid, 0);
        bus.link_en = 1'b1;
        gap();
        chk("dis_reenable", bus.link_state, 1);
        repeat (4) idle_k();
        repeat (3) cerr();
        chk("resync2_state", bus.link_state, 4);
        chk("err_cnt_8", bus.err_cnt, errs(8));
        repeat (2) gap();

        // asynchronous reset in RESYNC
        #2 rst = 1'b1;
        #1;
        chk("arst_state", bus.link_state, 0);
        chk("arst_resync_req", bus.resync_req, 0);
        chk("arst_link_up", bus.link_up, 0);
        chk("arst_rx_data", bus.rx_data, 0);
        chk("arst_err_cnt", bus.err_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        chk("post_rst_state", bus.link_state, 0);
        gap();
        chk("post_rst_hunt", bus.link_state, 1);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
